// File: rtl/csa_seq_alu.sv
// csa_seq_alu
// Byte-serial loaded, block-sequential carry-select ALU.
// Operands A and B are shifted in one byte at a time, LSB byte first.
// An accepted start processes one BLK-bit carry-select block per cycle,
// LSB block first. The registered inter-block carry chooses between the
// two precomputed block sums. The result is read back one byte at a time
// through a wrapping read pointer. The last pointer slot shows the flags.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   rst_n   : asynchronous active-low reset
//   ena     : design enable; when low every register holds
//   ui_in   : operand load byte
//   uio_in  : [0] load_a, [1] load_b, [2] start, [4:3] mode, [5] rd
//   uo_out  : byte P of R, or {6'b0, V, C} when P == WIDTH/8
//   uio_out : [7] done, [6] busy, [5:0] zero
//   uio_oe  : constant 8'b1100_0000
module csa_seq_alu #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NBLK  = WIDTH / BLK;
    localparam int NBYTE = WIDTH / 8;
    localparam int IW    = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int PW    = $clog2(NBYTE + 1);

    localparam logic [IW-1:0] LAST_BLK  = IW'(NBLK - 1);
    localparam logic [PW-1:0] FLAG_SLOT = PW'(NBYTE);

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_ADDC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry entering block 0: SUB adds ~B + 1, ADDC chains the stored carry.
    function automatic logic init_carry(input logic [1:0] mode, input logic c_prev);
        logic cin;
        case (mode)
            MODE_SUB:  cin = 1'b1;
            MODE_ADDC: cin = c_prev;
            default:   cin = 1'b0;
        endcase
        return cin;
    endfunction

    // Registers
    state_t          state_r;
    state_t          state_nx_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] r_r;
    logic             c_r;
    logic             v_r;
    logic [PW-1:0]    p_r;
    logic [IW-1:0]    blk_idx_r;
    logic [1:0]       mode_r;
    logic             carry_r;

    // Decoded controls
    logic       load_a_s;
    logic       load_b_s;
    logic       start_s;
    logic [1:0] mode_in_s;
    logic       rd_s;
    logic       load_any_s;
    logic       idle_or_done_s;
    logic       start_ok_s;
    logic       strobe_ok_s;
    logic       calc_step_s;
    logic       last_blk_s;
    logic       unused_s;

    assign load_a_s       = uio_in[0];
    assign load_b_s       = uio_in[1];
    assign start_s        = uio_in[2];
    assign mode_in_s      = uio_in[4:3];
    assign rd_s           = uio_in[5];
    assign unused_s       = ^uio_in[7:6];
    assign load_any_s     = load_a_s | load_b_s;
    assign idle_or_done_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    // A start sharing a cycle with a load strobe is dropped so the operands
    // are never changing underneath a freshly started operation.
    assign start_ok_s     = ena && start_s && !load_any_s && idle_or_done_s;
    // Load and rd strobes are honoured only while not computing.
    assign strobe_ok_s    = ena && (state_r != ST_CALC);
    assign calc_step_s    = ena && (state_r == ST_CALC);
    assign last_blk_s     = (blk_idx_r == LAST_BLK);

    // Byte shift-in: new byte enters at the top, so the first byte loaded
    // ends up as the least significant byte after WIDTH/8 loads.
    logic [WIDTH+7:0] a_cat_s;
    logic [WIDTH+7:0] b_cat_s;
    logic [WIDTH-1:0] a_shift_s;
    logic [WIDTH-1:0] b_shift_s;

    assign a_cat_s   = {ui_in, a_r};
    assign b_cat_s   = {ui_in, b_r};
    assign a_shift_s = a_cat_s[WIDTH+7:8];
    assign b_shift_s = b_cat_s[WIDTH+7:8];

    // Block datapath
    logic [31:0]    blk_base_s;
    logic [BLK-1:0] opx_s;
    logic [BLK-1:0] opy_s;
    logic [BLK:0]   sum0_s;
    logic [BLK:0]   sum1_s;
    logic [BLK:0]   sel_s;
    logic           msb_cin_s;

    assign blk_base_s = 32'(blk_idx_r) * 32'(BLK);

    // Carry-select block: both candidate sums formed, registered carry picks one.
    always_comb begin
        opx_s     = {BLK{1'b0}};
        opy_s     = {BLK{1'b0}};
        sum0_s    = {(BLK+1){1'b0}};
        sum1_s    = {(BLK+1){1'b0}};
        sel_s     = {(BLK+1){1'b0}};
        msb_cin_s = 1'b0;
        // ACC reuses R in place as the left operand; each block is read
        // in the same cycle it is overwritten, so no copy is needed.
        if (mode_r == MODE_ACC) begin
            opx_s = r_r[blk_base_s +: BLK];
        end else begin
            opx_s = a_r[blk_base_s +: BLK];
        end
        if (mode_r == MODE_SUB) begin
            opy_s = ~b_r[blk_base_s +: BLK];
        end else begin
            opy_s = b_r[blk_base_s +: BLK];
        end
        sum0_s = {1'b0, opx_s} + {1'b0, opy_s};
        sum1_s = {1'b0, opx_s} + {1'b0, opy_s} + {{BLK{1'b0}}, 1'b1};
        if (carry_r) begin
            sel_s = sum1_s;
        end else begin
            sel_s = sum0_s;
        end
        // Carry into the top bit of the block, recovered from its sum bit.
        msb_cin_s = opx_s[BLK-1] ^ opy_s[BLK-1] ^ sel_s[BLK-1];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        if (!ena) begin
            state_nx_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        state_nx_s = ST_CALC;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (last_blk_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_CALC;
                    end
                end
                ST_DONE: begin
                    // A load strobe clears done by returning to IDLE.
                    if (load_any_s) begin
                        state_nx_s = ST_IDLE;
                    end else if (start_ok_s) begin
                        state_nx_s = ST_CALC;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: busy while computing, done while holding a result.
    logic busy_s;
    logic done_s;

    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_CALC: busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Operand shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= {WIDTH{1'b0}};
            b_r <= {WIDTH{1'b0}};
        end else if (strobe_ok_s) begin
            if (load_a_s) begin
                a_r <= a_shift_s;
            end
            if (load_b_s) begin
                b_r <= b_shift_s;
            end
        end
    end

    // Operation control: mode latch, block index and inter-block carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r    <= MODE_ADD;
            blk_idx_r <= {IW{1'b0}};
            carry_r   <= 1'b0;
        end else if (start_ok_s) begin
            mode_r    <= mode_in_s;
            blk_idx_r <= {IW{1'b0}};
            carry_r   <= init_carry(mode_in_s, c_r);
        end else if (calc_step_s) begin
            carry_r <= sel_s[BLK];
            if (last_blk_s) begin
                blk_idx_r <= {IW{1'b0}};
            end else begin
                blk_idx_r <= blk_idx_r + IW'(1);
            end
        end
    end

    // Result register and flags; flags change only on the final block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r <= {WIDTH{1'b0}};
            c_r <= 1'b0;
            v_r <= 1'b0;
        end else if (calc_step_s) begin
            r_r[blk_base_s +: BLK] <= sel_s[BLK-1:0];
            if (last_blk_s) begin
                c_r <= sel_s[BLK];
                v_r <= msb_cin_s ^ sel_s[BLK];
            end
        end
    end

    // Read pointer: cleared on start, advanced and wrapped by rd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r <= {PW{1'b0}};
        end else if (start_ok_s) begin
            p_r <= {PW{1'b0}};
        end else if (strobe_ok_s && rd_s) begin
            if (p_r == FLAG_SLOT) begin
                p_r <= {PW{1'b0}};
            end else begin
                p_r <= p_r + PW'(1);
            end
        end
    end

    // Read-out mux: result byte selected by P, flags in the last slot.
    logic [7:0] rd_byte_s;

    always_comb begin
        rd_byte_s = {6'b00_0000, v_r, c_r};
        for (int i = 0; i < NBYTE; i++) begin
            if (p_r == PW'(i)) begin
                rd_byte_s = r_r[i*8 +: 8];
            end
        end
    end

    assign uo_out  = rd_byte_s;
    assign uio_out = {done_s, busy_s, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_csa_seq_alu.sv
module tb_csa_seq_alu;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int checks;
    int errors;
    int n;
    logic [15:0] r;
    logic [7:0]  f;

    csa_seq_alu #(.WIDTH(16), .BLK(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire busy = uio_out[6];
    wire done = uio_out[7];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Shift a 16-bit word in, low byte first, using the given load strobe.
    task automatic load_word(input logic [7:0] strobe, input logic [15:0] w);
        ui_in  = w[7:0];
        uio_in = strobe;
        cycle();
        ui_in  = w[15:8];
        cycle();
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    // Issue start with a mode and count the cycles busy stays high (bounded).
    task automatic run_op(input logic [1:0] mode, output int cnt);
        uio_in = {3'b000, mode, 3'b100};
        cycle();
        uio_in = 8'h00;
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            cnt++;
            cycle();
        end
    endtask

    // Read byte 0, byte 1 and flags with three rd strobes (pointer wraps to 0).
    task automatic read_all(output logic [15:0] res, output logic [7:0] flg);
        res[7:0] = uo_out;
        uio_in = 8'h20;
        cycle();
        res[15:8] = uo_out;
        cycle();
        flg = uo_out;
        cycle();
        uio_in = 8'h00;
    endtask

    task automatic test_reset();
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out: got %h expected 00", uo_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (uio_oe !== 8'hC0) begin errors++; $display("FAIL uio_oe: got %h expected c0", uio_oe); end
        rst_n = 1'b1;
        cycle();
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL post_reset_uio_out: got %h expected 00", uio_out); end
    endtask

    task automatic test_basic_add();
        load_word(8'h01, 16'h1234);
        load_word(8'h02, 16'h0FCD);
        run_op(2'b00, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL add_busy_cycles: got %0d expected 4", n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done: got %b expected 1", done); end
        read_all(r, f);
        checks++; if (r !== 16'h2201) begin errors++; $display("FAIL add_result: got %h expected 2201", r); end
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL add_flags: got %h expected 00", f); end
        checks++; if (uo_out !== 8'h01) begin errors++; $display("FAIL add_ptr_wrap: got %h expected 01", uo_out); end
    endtask

    task automatic test_sub_borrow();
        load_word(8'h01, 16'h0001);
        load_word(8'h02, 16'h0002);
        run_op(2'b01, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL sub_busy_cycles: got %0d expected 4", n); end
        read_all(r, f);
        checks++; if (r !== 16'hFFFF) begin errors++; $display("FAIL sub_result: got %h expected ffff", r); end
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL sub_flags: got %h expected 00", f); end
    endtask

    task automatic test_overflow_chain();
        load_word(8'h01, 16'h7FFF);
        load_word(8'h02, 16'h0001);
        run_op(2'b00, n);
        read_all(r, f);
        checks++; if (r !== 16'h8000) begin errors++; $display("FAIL ovf_result: got %h expected 8000", r); end
        checks++; if (f !== 8'h02) begin errors++; $display("FAIL ovf_flags: got %h expected 02", f); end
        load_word(8'h01, 16'hFFFF);
        load_word(8'h02, 16'h0001);
        run_op(2'b00, n);
        read_all(r, f);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL carry_result: got %h expected 0000", r); end
        checks++; if (f !== 8'h01) begin errors++; $display("FAIL carry_flags: got %h expected 01", f); end
        load_word(8'h03, 16'h0000);
        run_op(2'b11, n);
        read_all(r, f);
        checks++; if (r !== 16'h0001) begin errors++; $display("FAIL addc_result: got %h expected 0001", r); end
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL addc_flags: got %h expected 00", f); end
    endtask

    task automatic test_accumulate();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cycle();
        load_word(8'h02, 16'h0005);
        run_op(2'b10, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL acc1_busy_cycles: got %0d expected 4", n); end
        // Second pass: load and rd strobes while busy must be ignored.
        uio_in = 8'h14;
        cycle();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            if (n < 2) begin
                ui_in  = 8'hAA;
                uio_in = 8'h23;
            end else begin
                ui_in  = 8'h00;
                uio_in = 8'h00;
            end
            n++;
            cycle();
        end
        ui_in  = 8'h00;
        uio_in = 8'h00;
        checks++; if (n !== 4) begin errors++; $display("FAIL acc2_busy_cycles: got %0d expected 4", n); end
        checks++; if (uo_out !== 8'h0A) begin errors++; $display("FAIL acc2_ptr_held: got %h expected 0a", uo_out); end
        run_op(2'b10, n);
        read_all(r, f);
        checks++; if (r !== 16'h000F) begin errors++; $display("FAIL acc_result: got %h expected 000f", r); end
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL acc_flags: got %h expected 00", f); end
        // A must still be 0 and B still 5.
        run_op(2'b00, n);
        read_all(r, f);
        checks++; if (r !== 16'h0005) begin errors++; $display("FAIL acc_operands_held: got %h expected 0005", r); end
    endtask

    task automatic test_reset_mid();
        load_word(8'h01, 16'h1201);
        load_word(8'h02, 16'h2302);
        uio_in = 8'h04;
        cycle();
        uio_in = 8'h00;
        cycle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset_done: got %b expected 0", done); end
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL mid_reset_uo_out: got %h expected 00", uo_out); end
        #2;
        rst_n = 1'b1;
        cycle();
        checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL mid_release_idle: got %h expected 00", uio_out); end
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL mid_release_uo_out: got %h expected 00", uo_out); end
        load_word(8'h01, 16'h1201);
        load_word(8'h02, 16'h2302);
        run_op(2'b00, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL mid_add_busy_cycles: got %0d expected 4", n); end
        read_all(r, f);
        checks++; if (r !== 16'h3503) begin errors++; $display("FAIL mid_add_result: got %h expected 3503", r); end
        checks++; if (f !== 8'h00) begin errors++; $display("FAIL mid_add_flags: got %h expected 00", f); end
    endtask

    task automatic test_ena_low();
        ena    = 1'b0;
        uio_in = 8'h04;
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_start_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ena_start_done: got %b expected 1", done); end
        ui_in  = 8'hFF;
        uio_in = 8'h23;
        cycle();
        checks++; if (uo_out !== 8'h03) begin errors++; $display("FAIL ena_ptr_held: got %h expected 03", uo_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ena_load_done: got %b expected 1", done); end
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h20;
        cycle();
        checks++; if (uo_out !== 8'h35) begin errors++; $display("FAIL wrap_rd1: got %h expected 35", uo_out); end
        cycle();
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL wrap_rd2: got %h expected 00", uo_out); end
        cycle();
        checks++; if (uo_out !== 8'h03) begin errors++; $display("FAIL wrap_rd3: got %h expected 03", uo_out); end
        uio_in = 8'h00;
        // Restart straight from DONE with the held operands.
        run_op(2'b00, n);
        read_all(r, f);
        checks++; if (r !== 16'h3503) begin errors++; $display("FAIL ena_operands_held: got %h expected 3503", r); end
    endtask

    task automatic test_back_to_back();
        // Start with a load in the same cycle: load taken, start dropped, done cleared.
        ui_in  = 8'h00;
        uio_in = 8'h05;
        cycle();
        uio_in = 8'h00;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_dropped: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_cleared: got %b expected 0", done); end
        // A is now 0x0012 after one more shift-in of 0x00.
        run_op(2'b00, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 4", n); end
        read_all(r, f);
        checks++; if (r !== 16'h2314) begin errors++; $display("FAIL b2b_result: got %h expected 2314", r); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #3;
        test_reset();
        test_basic_add();
        test_sub_borrow();
        test_overflow_chain();
        test_accumulate();
        test_reset_mid();
        test_ena_low();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_seq_alu.md
CSA_SEQ_ALU -- requirements
Module: csa_seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 8 in 8..32.
REQ-002 SHALL have parameter BLK, default 4, carry-select block width in bits; BLK SHALL divide WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ena, input, 1 bit: design enable; when low, all registers hold and all strobes are ignored.
REQ-006 SHALL have port ui_in, input, 8 bits: operand load byte.
REQ-007 SHALL have port uio_in, input, 8 bits: control inputs.
- [0] load_a; [1] load_b; [2] start; [4:3] mode; [5] rd; [7:6] unused.
REQ-008 SHALL have port uo_out, output, 8 bits: the read-out byte selected by the read pointer.
REQ-009 SHALL have port uio_out, output, 8 bits: [6] busy, [7] done, [5:0] driven 0.
REQ-010 SHALL have port uio_oe, output, 8 bits: constant 8'b1100_0000.

Function
REQ-011 SHALL apply operand loading on every enabled cycle where load_a is high: A <= {ui_in, A[WIDTH-1:8]}, i.e. bytes are shifted in LSB byte first.
- load_b shifts B the same way.
- load_a and load_b MAY be high in the same cycle; both SHALL load ui_in.
REQ-012 SHALL implement modes:
- 00 ADD: R = A + B, cin = 0.
- 01 SUB: R = A + ~B, cin = 1; C = 1 means no borrow.
- 10 ACC: R = R + B, cin = 0; A is unused.
- 11 ADDC: R = A + B + C, where C is the stored carry from the previous operation.
REQ-013 SHALL implement an FSM with states IDLE, CALC and DONE.
- start is accepted only in IDLE or DONE, and only when no load strobe is high in the same cycle; otherwise start is ignored.
REQ-014 SHALL, on an accepted start, latch mode, clear the block index, and enter CALC.
REQ-015 SHALL, in CALC, process one BLK-bit block per cycle, LSB block first.
- Each block computes both candidate sums (carry-in 0 and carry-in 1) in parallel and selects one using the registered inter-block carry.
- The selected block result and carry are written into R and the carry register.
REQ-016 SHALL remain in CALC for exactly WIDTH/BLK cycles, then enter DONE.
- On the final cycle it SHALL update C (carry out) and V (signed overflow = carry into MSB XOR carry out of MSB).
REQ-017 SHALL assert busy exactly while in CALC.
- done SHALL be high in DONE and SHALL clear on the next accepted start or on any load strobe.
REQ-018 SHALL ignore load and rd strobes while busy; A, B and the pointer are unchanged.
REQ-019 SHALL maintain a read pointer P in the range 0..WIDTH/8.
- uo_out = byte P of R for P < WIDTH/8.
- uo_out = {6'b0, V, C} for P = WIDTH/8.
- rd increments P and wraps from WIDTH/8 to 0.
- An accepted start resets P to 0.
REQ-020 uo_out SHALL be combinational from R, C, V and P, with no added latency.
REQ-021 SHALL write intermediate R blocks in place during CALC; R is valid only in DONE.
REQ-022 C and V SHALL persist across operations until overwritten by the final cycle of the next CALC.

Reset
REQ-023 SHALL, while rst_n is low, immediately force:
- A, B, R = 0; C, V = 0; P = 0; block index = 0; state = IDLE.
- Resulting outputs: uo_out = 0, busy = 0, done = 0.
REQ-024 SHALL abort an in-progress CALC when rst_n is asserted mid-operation; no partial result is retained.
REQ-025 SHALL resume in IDLE on the first rising clk edge after rst_n deasserts, using no synchronous reset term.

Verification (WIDTH=16, BLK=4)
REQ-026 Basic add:
- Stimulus: load A bytes 0x34, 0x12; B bytes 0xCD, 0x0F; ADD, start.
- Response: busy high for 4 cycles, then done; rd sequence gives 0x01, 0x22, 0x00 (C=0, V=0).
REQ-027 Subtract with borrow:
- Stimulus: A=0x0001, B=0x0002, SUB.
- Response: R=0xFFFF; flags byte 0x00 (borrow, no overflow).
REQ-028 Signed overflow and carry chaining:
- A=0x7FFF, B=0x0001, ADD -> R=0x8000, flags 0x02.
- Then A=0xFFFF, B=0x0001, ADD -> R=0x0000, flags 0x01.
- Then A=0x0000, B=0x0000, ADDC -> R=0x0001.
REQ-029 Accumulate:
- Stimulus: after reset, B=0x0005, ACC started three times.
- Response: R=0x000F; load or rd strobes during busy leave A, B and P unchanged.
REQ-030 Reset mid-operation:
- Stimulus: rst_n low in the 2nd CALC cycle.
- Response: busy, done and uo_out are 0 immediately; after release, state is IDLE and a new ADD completes correctly.
REQ-031 ena low:
- Stimulus: ena low with start and load strobes active.
- Response: no state change; pointer wrap confirmed across 3 rd strobes, returning to byte 0.
